// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the IFU/LSU clients, the arbiter and the data-memory port.
// slave is the arbiter's view; master is the view of whatever drives the clients and memory.
interface mem_arbiter_if;
   logic        ifu_valid;
   logic [31:0] ifu_addr;
   logic        ifu_ready;
   logic        ifu_rvalid;
   logic [31:0] ifu_rdata;
   logic        ifu_err;

   logic        lsu_valid;
   logic        lsu_wen;
   logic [2:0]  lsu_op;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic        lsu_ready;
   logic        lsu_rvalid;
   logic [31:0] lsu_rdata;
   logic        lsu_err;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport slave (
      input  ifu_valid, ifu_addr,
      output ifu_ready, ifu_rvalid, ifu_rdata, ifu_err,
      input  lsu_valid, lsu_wen, lsu_op, lsu_addr, lsu_wdata,
      output lsu_ready, lsu_rvalid, lsu_rdata, lsu_err,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      input  mem_ack, mem_rdata
   );

   modport master (
      output ifu_valid, ifu_addr,
      input  ifu_ready, ifu_rvalid, ifu_rdata, ifu_err,
      output lsu_valid, lsu_wen, lsu_op, lsu_addr, lsu_wdata,
      input  lsu_ready, lsu_rvalid, lsu_rdata, lsu_err,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one word-wide memory port between instruction fetch and load/store.
// Handles byte/half lane placement for stores and lane extraction plus extension for loads.
module mem_arbiter (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   typedef enum logic {StIdle, StBusy} state_e;

   state_e      state_q, state_d;
   logic        last_lsu_q, last_lsu_d;
   logic        owner_lsu_q, owner_lsu_d;
   logic [2:0]  op_q, op_d;
   logic [1:0]  off_q, off_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wmask_q, mem_wmask_d;
   logic        ifu_rvalid_q, ifu_rvalid_d;
   logic        ifu_err_q, ifu_err_d;
   logic [31:0] ifu_rdata_q, ifu_rdata_d;
   logic        lsu_rvalid_q, lsu_rvalid_d;
   logic        lsu_err_q, lsu_err_d;
   logic [31:0] lsu_rdata_q, lsu_rdata_d;

   logic        idle, grant_ifu, grant_lsu;
   logic        ifu_bad, lsu_bad;
   logic [1:0]  lsu_off;
   logic [4:0]  lsu_sh;
   logic [31:0] st_data;
   logic [3:0]  st_mask;
   logic [31:0] ld_lane, ld_data;

   assign idle      = (state_q == StIdle);
   // On a tie the requester that did not win last time gets the port.
   assign grant_ifu = idle && bus.ifu_valid && (!bus.lsu_valid || last_lsu_q);
   assign grant_lsu = idle && bus.lsu_valid && (!bus.ifu_valid || !last_lsu_q);

   always_comb begin
      lsu_off = bus.lsu_addr[1:0];
      lsu_sh  = {lsu_off, 3'b000};
      ifu_bad = (bus.ifu_addr[1:0] != 2'b00);
      case (bus.lsu_op)
         3'b000:  lsu_bad = 1'b0;
         3'b100:  lsu_bad = bus.lsu_wen;
         3'b001:  lsu_bad = (lsu_off == 2'd3);
         3'b101:  lsu_bad = bus.lsu_wen || (lsu_off == 2'd3);
         3'b010:  lsu_bad = (lsu_off != 2'd0);
         default: lsu_bad = 1'b1;
      endcase
      st_data = '0;
      st_mask = '0;
      if (bus.lsu_wen) begin
         case (bus.lsu_op[1:0])
            2'b00: begin
               st_data = {24'h0, bus.lsu_wdata[7:0]} << lsu_sh;
               st_mask = 4'b0001 << lsu_off;
            end
            2'b01: begin
               st_data = {16'h0, bus.lsu_wdata[15:0]} << lsu_sh;
               st_mask = 4'b0011 << lsu_off;
            end
            default: begin
               st_data = bus.lsu_wdata;
               st_mask = 4'b1111;
            end
         endcase
      end
   end

   always_comb begin
      ld_lane = bus.mem_rdata >> {off_q, 3'b000};
      case (op_q)
         3'b000:  ld_data = {{24{ld_lane[7]}}, ld_lane[7:0]};
         3'b100:  ld_data = {24'h0, ld_lane[7:0]};
         3'b001:  ld_data = {{16{ld_lane[15]}}, ld_lane[15:0]};
         3'b101:  ld_data = {16'h0, ld_lane[15:0]};
         default: ld_data = bus.mem_rdata;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      last_lsu_d   = last_lsu_q;
      owner_lsu_d  = owner_lsu_q;
      op_d         = op_q;
      off_d        = off_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wmask_d  = mem_wmask_q;
      ifu_rvalid_d = 1'b0;
      ifu_err_d    = 1'b0;
      ifu_rdata_d  = ifu_rdata_q;
      lsu_rvalid_d = 1'b0;
      lsu_err_d    = 1'b0;
      lsu_rdata_d  = lsu_rdata_q;
      unique case (state_q)
         StIdle: begin
            if (grant_ifu) begin
               last_lsu_d = 1'b0;
               if (ifu_bad) begin
                  ifu_err_d = 1'b1;
               end else begin
                  state_d     = StBusy;
                  owner_lsu_d = 1'b0;
                  op_d        = 3'b010;
                  off_d       = 2'b00;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = {bus.ifu_addr[31:2], 2'b00};
                  mem_wdata_d = '0;
                  mem_wmask_d = '0;
               end
            end else if (grant_lsu) begin
               last_lsu_d = 1'b1;
               if (lsu_bad) begin
                  lsu_err_d = 1'b1;
               end else begin
                  state_d     = StBusy;
                  owner_lsu_d = 1'b1;
                  op_d        = bus.lsu_op;
                  off_d       = lsu_off;
                  mem_we_d    = bus.lsu_wen;
                  mem_addr_d  = {bus.lsu_addr[31:2], 2'b00};
                  mem_wdata_d = st_data;
                  mem_wmask_d = st_mask;
               end
            end
         end
         StBusy: begin
            if (bus.mem_ack) begin
               state_d = StIdle;
               if (owner_lsu_q) begin
                  lsu_rvalid_d = 1'b1;
                  lsu_rdata_d  = mem_we_q ? 32'h0 : ld_data;
               end else begin
                  ifu_rvalid_d = 1'b1;
                  ifu_rdata_d  = bus.mem_rdata;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         last_lsu_q   <= 1'b1;
         owner_lsu_q  <= 1'b0;
         op_q         <= '0;
         off_q        <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wmask_q  <= '0;
         ifu_rvalid_q <= 1'b0;
         ifu_err_q    <= 1'b0;
         ifu_rdata_q  <= '0;
         lsu_rvalid_q <= 1'b0;
         lsu_err_q    <= 1'b0;
         lsu_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_lsu_q   <= last_lsu_d;
         owner_lsu_q  <= owner_lsu_d;
         op_q         <= op_d;
         off_q        <= off_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wmask_q  <= mem_wmask_d;
         ifu_rvalid_q <= ifu_rvalid_d;
         ifu_err_q    <= ifu_err_d;
         ifu_rdata_q  <= ifu_rdata_d;
         lsu_rvalid_q <= lsu_rvalid_d;
         lsu_err_q    <= lsu_err_d;
         lsu_rdata_q  <= lsu_rdata_d;
      end
   end

   assign bus.ifu_ready  = grant_ifu;
   assign bus.ifu_rvalid = ifu_rvalid_q;
   assign bus.ifu_rdata  = ifu_rdata_q;
   assign bus.ifu_err    = ifu_err_q;
   assign bus.lsu_ready  = grant_lsu;
   assign bus.lsu_rvalid = lsu_rvalid_q;
   assign bus.lsu_rdata  = lsu_rdata_q;
   assign bus.lsu_err    = lsu_err_q;
   assign bus.mem_req    = (state_q == StBusy);
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.mem_wmask  = mem_wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: lane handling, round-robin grants, illegal accesses,
// memory wait states and reset during a transaction.
module tb_mem_arbiter;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   mem_arbiter_if bus ();

   mem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled at the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic lsu_req(input logic wen, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata);
      bus.lsu_valid = 1'b1;
      bus.lsu_wen   = wen;
      bus.lsu_op    = op;
      bus.lsu_addr  = addr;
      bus.lsu_wdata = wdata;
      #1;
      chk("lsu_ready", {31'h0, bus.lsu_ready}, 32'h1);
      tick();
      bus.lsu_valid = 1'b0;
   endtask

   task automatic ifu_req(input logic [31:0] addr);
      bus.ifu_valid = 1'b1;
      bus.ifu_addr  = addr;
      #1;
      chk("ifu_ready", {31'h0, bus.ifu_ready}, 32'h1);
      tick();
      bus.ifu_valid = 1'b0;
   endtask

   task automatic ack(input logic [31:0] data);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = data;
      tick();
      bus.mem_ack   = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      bus.ifu_valid = 1'b0;
      bus.ifu_addr  = '0;
      bus.lsu_valid = 1'b0;
      bus.lsu_wen   = 1'b0;
      bus.lsu_op    = '0;
      bus.lsu_addr  = '0;
      bus.lsu_wdata = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      @(negedge clk);
      tick();

      chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_ifu_rvalid", {31'h0, bus.ifu_rvalid}, 32'h0);
      chk("rst_lsu_rvalid", {31'h0, bus.lsu_rvalid}, 32'h0);
      chk("rst_lsu_rdata", bus.lsu_rdata, 32'h0);
      chk("rst_errs", {30'h0, bus.ifu_err, bus.lsu_err}, 32'h0);
      rst = 1'b0;

      // lb / lbu at offset 3
      lsu_req(1'b0, 3'b000, 32'h0000_1003, 32'h0);
      chk("lb_mem_req", {31'h0, bus.mem_req}, 32'h1);
      chk("lb_mem_addr", bus.mem_addr, 32'h0000_1000);
      chk("lb_mask_we", {27'h0, bus.mem_we, bus.mem_wmask}, 32'h0);
      ack(32'h80FF_FF12);
      chk("lb_rvalid", {31'h0, bus.lsu_rvalid}, 32'h1);
      chk("lb_rdata", bus.lsu_rdata, 32'hFFFF_FF80);
      chk("lb_mem_req_done", {31'h0, bus.mem_req}, 32'h0);
      tick();
      chk("lb_rvalid_pulse", {31'h0, bus.lsu_rvalid}, 32'h0);
      chk("lb_rdata_hold", bus.lsu_rdata, 32'hFFFF_FF80);
      lsu_req(1'b0, 3'b100, 32'h0000_1003, 32'h0);
      ack(32'h80FF_FF12);
      chk("lbu_rdata", bus.lsu_rdata, 32'h0000_0080);

      // lh at offset 1
      lsu_req(1'b0, 3'b001, 32'h0000_1001, 32'h0);
      ack(32'h12AB_CD34);
      chk("lh_rdata", bus.lsu_rdata, 32'hFFFF_ABCD);

      // sh at offset 2, sb at offset 1
      lsu_req(1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF);
      chk("sh_mem_addr", bus.mem_addr, 32'h0000_2000);
      chk("sh_mem_wmask", {28'h0, bus.mem_wmask}, 32'hC);
      chk("sh_mem_wdata", bus.mem_wdata, 32'hBEEF_0000);
      chk("sh_mem_we", {31'h0, bus.mem_we}, 32'h1);
      ack(32'h5555_5555);
      chk("sh_rvalid", {31'h0, bus.lsu_rvalid}, 32'h1);
      chk("sh_rdata", bus.lsu_rdata, 32'h0);
      lsu_req(1'b1, 3'b000, 32'h0000_3001, 32'h1234_5678);
      chk("sb_mem_wmask", {28'h0, bus.mem_wmask}, 32'h2);
      chk("sb_mem_wdata", bus.mem_wdata, 32'h0000_7800);
      ack(32'h0);

      // Round robin from reset with both requesters held valid and ack held high
      rst = 1'b1;
      tick();
      rst           = 1'b0;
      bus.ifu_valid = 1'b1;
      bus.ifu_addr  = 32'h8000_0000;
      bus.lsu_valid = 1'b1;
      bus.lsu_wen   = 1'b0;
      bus.lsu_op    = 3'b010;
      bus.lsu_addr  = 32'h0000_0100;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h1122_3344;
      for (int g = 0; g < 4; g++) begin
         #1;
         chk("rr_ifu_ready", {31'h0, bus.ifu_ready}, (g % 2 == 0) ? 32'h1 : 32'h0);
         chk("rr_lsu_ready", {31'h0, bus.lsu_ready}, (g % 2 == 0) ? 32'h0 : 32'h1);
         if (g > 0) begin
            chk("rr_prev_rvalid", {30'h0, bus.ifu_rvalid, bus.lsu_rvalid},
                (g % 2 == 0) ? 32'h1 : 32'h2);
         end
         tick();
         chk("rr_busy_readies", {30'h0, bus.ifu_ready, bus.lsu_ready}, 32'h0);
         chk("rr_mem_addr", bus.mem_addr, (g % 2 == 0) ? 32'h8000_0000 : 32'h0000_0100);
         tick();
      end
      chk("rr_last_rvalid", {30'h0, bus.ifu_rvalid, bus.lsu_rvalid}, 32'h1);
      chk("rr_lsu_rdata", bus.lsu_rdata, 32'h1122_3344);
      chk("rr_ifu_rdata", bus.ifu_rdata, 32'h1122_3344);
      bus.ifu_valid = 1'b0;
      bus.lsu_valid = 1'b0;
      bus.mem_ack   = 1'b0;
      tick();

      // Illegal requests are consumed and answered with err, no memory access
      lsu_req(1'b0, 3'b010, 32'h0000_1002, 32'h0);
      chk("lw_mis_err", {31'h0, bus.lsu_err}, 32'h1);
      chk("lw_mis_req", {31'h0, bus.mem_req}, 32'h0);
      chk("lw_mis_rvalid", {31'h0, bus.lsu_rvalid}, 32'h0);
      tick();
      chk("lw_mis_err_pulse", {31'h0, bus.lsu_err}, 32'h0);
      chk("lw_mis_req2", {31'h0, bus.mem_req}, 32'h0);
      lsu_req(1'b0, 3'b001, 32'h0000_1003, 32'h0);
      chk("lh_mis_err", {31'h0, bus.lsu_err}, 32'h1);
      chk("lh_mis_req", {31'h0, bus.mem_req}, 32'h0);
      lsu_req(1'b0, 3'b011, 32'h0000_1000, 32'h0);
      chk("op011_err", {31'h0, bus.lsu_err}, 32'h1);
      chk("op011_req", {31'h0, bus.mem_req}, 32'h0);
      lsu_req(1'b1, 3'b100, 32'h0000_1000, 32'h0);
      chk("sbu_err", {31'h0, bus.lsu_err}, 32'h1);
      ifu_req(32'h0000_0002);
      chk("ifu_mis_err", {31'h0, bus.ifu_err}, 32'h1);
      chk("ifu_mis_req", {31'h0, bus.mem_req}, 32'h0);
      chk("ifu_mis_lsu_err", {31'h0, bus.lsu_err}, 32'h0);
      tick();

      // Delayed ack: no grants while busy, single rvalid after ack
      ifu_req(32'h0000_0040);
      bus.ifu_valid = 1'b1;
      bus.ifu_addr  = 32'h0000_0044;
      bus.lsu_valid = 1'b1;
      bus.lsu_op    = 3'b010;
      bus.lsu_addr  = 32'h0000_0200;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("wait_readies", {30'h0, bus.ifu_ready, bus.lsu_ready}, 32'h0);
         chk("wait_mem_req", {31'h0, bus.mem_req}, 32'h1);
         chk("wait_mem_addr", bus.mem_addr, 32'h0000_0040);
         chk("wait_rvalid", {30'h0, bus.ifu_rvalid, bus.lsu_rvalid}, 32'h0);
         tick();
      end
      bus.ifu_valid = 1'b0;
      bus.lsu_valid = 1'b0;
      ack(32'hCAFE_F00D);
      chk("wait_ifu_rvalid", {30'h0, bus.ifu_rvalid, bus.lsu_rvalid}, 32'h2);
      chk("wait_ifu_rdata", bus.ifu_rdata, 32'hCAFE_F00D);
      chk("wait_req_done", {31'h0, bus.mem_req}, 32'h0);
      tick();
      chk("wait_one_rvalid", {30'h0, bus.ifu_rvalid, bus.lsu_rvalid}, 32'h0);

      // Ack while idle is ignored
      ack(32'hFFFF_FFFF);
      chk("idle_ack_rvalid", {30'h0, bus.ifu_rvalid, bus.lsu_rvalid}, 32'h0);
      chk("idle_ack_req", {31'h0, bus.mem_req}, 32'h0);
      chk("idle_ack_rdata", bus.ifu_rdata, 32'hCAFE_F00D);

      // Reset in the second busy cycle abandons the fetch
      ifu_req(32'h0000_0080);
      tick();
      chk("rstb_mem_req", {31'h0, bus.mem_req}, 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstb_req_low", {31'h0, bus.mem_req}, 32'h0);
      chk("rstb_ifu_rdata", bus.ifu_rdata, 32'h0);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("rstb_no_rvalid", {30'h0, bus.ifu_rvalid, bus.lsu_rvalid}, 32'h0);
      ifu_req(32'h0000_0084);
      chk("post_rst_addr", bus.mem_addr, 32'h0000_0084);
      ack(32'h1234_5678);
      chk("post_rst_rvalid", {31'h0, bus.ifu_rvalid}, 32'h1);
      chk("post_rst_rdata", bus.ifu_rdata, 32'h1234_5678);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
